// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: RV32I fetch sequencer owning the fetch PC, one outstanding imem
// request and a one-entry decode buffer. Optional macro: IFU_MISALIGN_TRAP_EN.
module ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redir_valid,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] pc_AB,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        misalign_err
);

  localparam logic [2:0] S_BOOT = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_OUT  = 3'd3;
`ifdef IFU_MISALIGN_TRAP_EN
  localparam logic [2:0] S_TRAP = 3'd4;
`endif

  logic [2:0]  state;
  logic [31:0] req_addr;
  logic [31:0] fetch_pc;
  logic [31:0] target;
  logic        kill;
  logic        redir;
  logic        hold;
  logic        bad_tgt;
  logic        go_redir;

  assign redir    = redir_valid && (pc_sel == 2'b10);
  assign hold     = redir_valid && (pc_sel == 2'b00);
  assign go_redir = redir && !bad_tgt;

`ifdef IFU_MISALIGN_TRAP_EN
  logic err;
  logic trap_pend;
  logic to_trap;

  assign target       = pc_AB;
  assign bad_tgt      = redir && (pc_AB[1:0] != 2'b00);
  assign to_trap      = bad_tgt || (trap_pend && !go_redir);
  assign misalign_err = err;

  // trap_pend: a misaligned redirect is waiting for the in-flight response to drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err       <= 1'b0;
      trap_pend <= 1'b0;
    end else if (go_redir) begin
      err       <= 1'b0;
      trap_pend <= 1'b0;
    end else if (bad_tgt) begin
      err       <= 1'b1;
      trap_pend <= (state == S_REQ) || ((state == S_WAIT) && !imem_rvalid);
    end else if ((state == S_WAIT) && imem_rvalid) begin
      trap_pend <= 1'b0;
    end
  end
`else
  assign target       = pc_AB & 32'hFFFF_FFFC;
  assign bad_tgt      = 1'b0;
  assign misalign_err = 1'b0;
`endif

  assign imem_req    = (state == S_REQ);
  assign imem_addr   = req_addr;
  assign instr_valid = (state == S_OUT) && !hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_BOOT;
      req_addr <= RESET_PC;
      fetch_pc <= RESET_PC;
      kill     <= 1'b0;
      instr    <= '0;
      instr_pc <= RESET_PC;
    end else begin
      case (state)
        S_BOOT: begin
          if (go_redir) begin
            state    <= S_REQ;
            req_addr <= target;
            fetch_pc <= target;
          end
`ifdef IFU_MISALIGN_TRAP_EN
          else if (bad_tgt) state <= S_TRAP;
`endif
          else if (!hold) begin
            state    <= S_REQ;
            req_addr <= fetch_pc;
          end
        end
        S_REQ: begin
          // once killed, fetch_pc already holds the redirect target and must not advance
          if (go_redir) fetch_pc <= target;
          else if (imem_gnt && !kill && !redir) fetch_pc <= req_addr + 32'd4;
          if (redir) kill <= 1'b1;
          if (imem_gnt) state <= S_WAIT;
        end
        S_WAIT: begin
          if (go_redir) fetch_pc <= target;
          if (redir) kill <= 1'b1;
          if (imem_rvalid) begin
            if (kill || redir) begin
              kill <= 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
              if (to_trap) state <= S_TRAP;
              else
`endif
              begin
                state    <= S_REQ;
                req_addr <= go_redir ? target : fetch_pc;
              end
            end else begin
              instr    <= imem_rdata;
              instr_pc <= req_addr;
              state    <= S_OUT;
            end
          end
        end
        S_OUT: begin
          if (go_redir) begin
            state    <= S_REQ;
            req_addr <= target;
            fetch_pc <= target;
          end
`ifdef IFU_MISALIGN_TRAP_EN
          else if (bad_tgt) state <= S_TRAP;
`endif
          else if (instr_valid && instr_ready) begin
            state    <= S_REQ;
            req_addr <= fetch_pc;
          end
        end
`ifdef IFU_MISALIGN_TRAP_EN
        S_TRAP: begin
          if (go_redir) begin
            state    <= S_REQ;
            req_addr <= target;
            fetch_pc <= target;
          end
        end
`endif
        default: state <= S_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Scoreboard bench for ifu_fetch_ctrl: the expected PC stream is queued when
// redirects are issued; a monitor pops and compares on every decode handshake.
module tb_ifu_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        redir_valid;
  logic [1:0]  pc_sel;
  logic [31:0] pc_AB;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        misalign_err;

  ifu_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .redir_valid(redir_valid), .pc_sel(pc_sel), .pc_AB(pc_AB),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned accepts  = 0;
  logic [31:0] exp_q[$];
  bit          err_m     = 1'b0;
  bit          fast_mem  = 1'b1;
  bit          gnt_block = 1'b0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic restart_stream(input logic [31:0] base);
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic model_redirect(input logic [31:0] t);
`ifdef IFU_MISALIGN_TRAP_EN
    if (t[1:0] != 2'b00) begin
      exp_q.delete();
      err_m = 1'b1;
    end else begin
      err_m = 1'b0;
      restart_stream(t);
    end
`else
    restart_stream(t & 32'hFFFF_FFFC);
`endif
  endtask

  // inputs at negedge, memory at +1, monitor at +2, model update at +3
  task automatic step(input bit rv, input logic [1:0] sel, input logic [31:0] ab, input bit rdy);
    @(negedge clk);
    redir_valid = rv;
    pc_sel      = sel;
    pc_AB       = ab;
    instr_ready = rdy;
    #3;
    if (rv && sel == 2'b10) model_redirect(ab);
  endtask

  task automatic run_until(input int unsigned n, input int unsigned budget, input string name);
    int unsigned start;
    start = accepts;
    for (int unsigned i = 0; i < budget && accepts < start + n; i++) step(1'b0, 2'b01, '0, 1'b1);
    check(name, 32'(accepts - start >= n), 32'd1);
  endtask

  // instruction memory: one outstanding access, random or zero-wait timing
  initial begin
    int unsigned lat;
    logic [31:0] addr, gaddr;
    bit pend, stale, gnt_prev;
    pend = 0; stale = 0; gnt_prev = 0; lat = 0; addr = '0; gaddr = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    forever begin
      @(negedge clk); #1;
      imem_rvalid = 1'b0;
      if (rst) begin
        if (pend || gnt_prev) stale = 1;
        pend = 0; gnt_prev = 0; imem_gnt = 1'b0;
      end else begin
        if (gnt_prev) begin
          pend = 1;
          addr = gaddr;
          lat  = fast_mem ? 1 : $urandom_range(1, 3);
        end
        if (stale) begin
          imem_rvalid = 1'b1;
          imem_rdata  = 32'hDEAD_BEEF;
          stale = 0;
        end else if (pend) begin
          lat--;
          if (lat == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_of(addr);
            pend = 0;
          end
        end
        imem_gnt = imem_req && !gnt_block && (fast_mem || $urandom_range(0, 9) < 6);
        gnt_prev = imem_gnt;
        gaddr    = imem_addr;
      end
    end
  end

  // monitor: scoreboard pop on handshake plus per-cycle protocol checks
  initial begin
    logic [31:0] p_instr, p_pc, p_addr, e;
    bit p_stall, p_wait, h, r;
    p_stall = 0; p_wait = 0; p_instr = '0; p_pc = '0; p_addr = '0;
    forever begin
      @(negedge clk); #2;
      if (rst !== 1'b0) begin
        p_stall = 0;
        p_wait  = 0;
        continue;
      end
      h = redir_valid && (pc_sel == 2'b00);
      r = redir_valid && (pc_sel == 2'b10);
      if (p_stall) begin
        check("stall_instr", instr, p_instr);
        check("stall_pc", instr_pc, p_pc);
        check("stall_no_req", 32'(imem_req), 32'd0);
        if (!h) check("stall_valid", 32'(instr_valid), 32'd1);
      end
      if (h) check("hold_valid_low", 32'(instr_valid), 32'd0);
      if (p_wait) begin
        check("req_held", 32'(imem_req), 32'd1);
        check("req_addr_stable", imem_addr, p_addr);
      end
      if (imem_req) check("addr_aligned", 32'(imem_addr[1:0]), 32'd0);
      check("misalign_err", 32'(misalign_err), 32'(err_m));
      if (instr_valid && instr_ready) begin
        accepts++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_instr actual_pc=%h expected=none", instr_pc);
        end else begin
          e = exp_q.pop_front();
          check("instr_pc", instr_pc, e);
          check("instr_data", instr, word_of(e));
        end
      end
      p_stall = instr_valid && !instr_ready && !r;
      p_instr = instr;
      p_pc    = instr_pc;
      p_wait  = imem_req && !imem_gnt;
      p_addr  = imem_addr;
    end
  end

  initial begin
    logic [31:0] a0, ab;
    logic [1:0]  sel;
    rst = 1'b1; redir_valid = 1'b0; pc_sel = 2'b01; pc_AB = '0; instr_ready = 1'b0;
    restart_stream(RST_PC);
    repeat (3) @(negedge clk);
    #2;
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_imem_addr", imem_addr, RST_PC);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, RST_PC);
    check("rst_misalign_err", 32'(misalign_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 2'b01, '0, 1'b1);
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, RST_PC);
    run_until(3, 40, "boot_three_fetches");

    // redirect while waiting for read data: response dropped, target requested next
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 2'b01, '0, 1'b1);
      if (imem_req && imem_gnt) break;
    end
    step(1'b1, 2'b10, 32'h0000_0200, 1'b1);
    step(1'b0, 2'b01, '0, 1'b1);
    check("wait_redir_req", 32'(imem_req), 32'd1);
    check("wait_redir_addr", imem_addr, 32'h0000_0200);
    check("wait_redir_no_valid", 32'(instr_valid), 32'd0);
    run_until(2, 30, "fetch_0x200");

    // grant withheld while a redirect arrives
    gnt_block = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 2'b01, '0, 1'b1);
      if (imem_req) break;
    end
    check("gnt_wait_req", 32'(imem_req), 32'd1);
    a0 = imem_addr;
    step(1'b1, 2'b10, 32'h0000_0300, 1'b1);
    check("gnt_wait_addr0", imem_addr, a0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 2'b01, '0, 1'b1);
      check("gnt_wait_addr", imem_addr, a0);
    end
    gnt_block = 1'b0;
    run_until(2, 30, "fetch_0x300");

    // decode back-pressure, then hold on the handshake cycle
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 2'b01, '0, 1'b0);
      if (instr_valid) break;
    end
    check("stall_reached", 32'(instr_valid), 32'd1);
    repeat (5) step(1'b0, 2'b01, '0, 1'b0);
    step(1'b1, 2'b00, '0, 1'b1);
    check("hold_no_req", 32'(imem_req), 32'd0);
    step(1'b0, 2'b01, '0, 1'b1);
    check("after_hold_valid", 32'(instr_valid), 32'd1);
    step(1'b0, 2'b01, '0, 1'b1);
    check("after_hs_req", 32'(imem_req), 32'd1);

    // address wrap at the top of the space
    step(1'b1, 2'b10, 32'hFFFF_FFF8, 1'b1);
    run_until(3, 40, "wrap_fetches");

    // misaligned redirect target
    step(1'b1, 2'b10, 32'h0000_0402, 1'b1);
`ifdef IFU_MISALIGN_TRAP_EN
    repeat (12) step(1'b0, 2'b01, '0, 1'b1);
    check("trap_err", 32'(misalign_err), 32'd1);
    check("trap_no_req", 32'(imem_req), 32'd0);
    check("trap_no_valid", 32'(instr_valid), 32'd0);
    step(1'b1, 2'b10, 32'h0000_0400, 1'b1);
    run_until(1, 30, "trap_resume_0x400");
`else
    run_until(1, 30, "misalign_fetch_0x400");
`endif

    // randomized traffic with occasional mid-transaction resets
    fast_mem = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1000 || c == 2000) begin
        @(negedge clk);
        rst = 1'b1; redir_valid = 1'b0; instr_ready = 1'b0;
        restart_stream(RST_PC);
        err_m = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        continue;
      end
      sel = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       ab = 32'hFFFF_FFF0 | ($urandom() & 32'h0000_000C);
        1:       ab = ($urandom() & 32'h0000_FFFC) | 32'($urandom_range(1, 3));
        default: ab = $urandom() & 32'h0000_FFFC;
      endcase
      step($urandom_range(0, 7) == 0, sel, ab, $urandom_range(0, 9) < 7);
    end
    check("total_accepts", 32'(accepts > 100), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
